pic_priority_core: RTL and testbench
====================================

Name: pic_priority_core

Overview:
- Parametrised, synchronous successor to the PIC control unit. Provides NUM_IR request lines, IRR/ISR/IMR registers, and fully-nested or rotating priority.
- Performs the two-pulse INTA vector handshake, with non-specific EOI and AEOI.
- Sits between the ICW/OCW register decoder (source of mode/mask/command strobes) and the CPU-side bus driver (consumer of the vector).

Parameters:
- NUM_IR, 8, number of interrupt request lines (2..16).
- ID_W, $clog2(NUM_IR), width of the IR index.
- VEC_W, 8, vector width. Vector = {base_vec, id}, so base_vec is VEC_W-ID_W bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ir_in  in  NUM_IR  raw interrupt requests, already synchronised
- level_mode  in  1  1 = level-triggered, 0 = edge-triggered (ICW1 LTIM)
- rotate_mode  in  1  1 = rotating priority, 0 = fully nested (OCW2 R)
- aeoi  in  1  automatic EOI on second INTA (ICW4)
- base_vec  in  VEC_W-ID_W  upper vector bits (ICW2)
- imr_wr  in  1  one-cycle strobe; load imr_data into IMR
- imr_data  in  NUM_IR  new mask, 1 = masked
- eoi  in  1  one-cycle non-specific EOI strobe
- inta  in  1  one-cycle strobe per INTA pulse from the bus interface
- int_out  out  1  interrupt request to CPU
- vector  out  VEC_W  vector, valid with vector_valid
- vector_valid  out  1  one-cycle strobe on second INTA
- irr  out  NUM_IR  IRR contents
- isr  out  NUM_IR  ISR contents
- imr  out  NUM_IR  IMR contents

Behaviour:
- Reset values: IRR=0, ISR=0, IMR=0, ir_prev=0, prio_ptr=0, state=IDLE, int_out=0, vector=0, vector_valid=0.
- Reset takes priority over all strobes and aborts any handshake in progress.
- IRR capture:
  - Edge mode: IRR[i] is set when ir_prev[i]=0 and ir_in[i]=1.
  - Level mode: IRR[i] = ir_in[i] each cycle.
  - ir_prev is registered every cycle.
- Priority:
  - Fully nested: index 0 is highest.
  - Rotating: prio_ptr is the highest index and priority descends modulo NUM_IR.
  - A candidate is the highest-priority bit of IRR & ~IMR.
  - int_out is asserted when the candidate exists and is strictly higher in priority than the highest ISR bit (or ISR=0).
  - int_out is registered, giving 2 cycles of latency from the ir_in rise to int_out.
- FSM states: IDLE, ACK1, ACK2.
  - IDLE -> ACK1 on inta while int_out=1.
    - Latch sel_id = current candidate and set ISR[sel_id].
    - Clear IRR[sel_id] in edge mode.
    - If no candidate exists at this point (request withdrawn), latch sel_id=NUM_IR-1, flag spurious, and leave ISR unchanged.
  - inta in IDLE while int_out=0 is ignored.
  - ACK1 -> ACK2 on the next inta.
    - vector <= {base_vec, sel_id} and vector_valid=1 for one cycle.
    - If aeoi and not spurious: clear ISR[sel_id]; in rotate_mode, prio_ptr <= sel_id+1 mod NUM_IR.
  - ACK2 -> IDLE unconditionally on the next cycle.
  - int_out is forced to 0 in ACK1 and ACK2.
- EOI:
  - Clears the highest-priority ISR bit under the current priority order.
  - In rotate_mode, prio_ptr <= cleared index+1 mod NUM_IR.
  - EOI with ISR=0 is a no-op.
- Simultaneous events:
  - An edge arriving in the same cycle as the IRR clear for that id wins: IRR stays set.
  - eoi and inta in the same cycle: EOI is applied to ISR first, then the inta set.
  - imr_wr takes effect on the next cycle's candidate.
  - imr_wr during ACK1 does not alter sel_id.

Optional Feature:
- Macro POLL_EN.
- Enabled:
  - Adds input poll (one-cycle strobe) and outputs poll_data[7:0] and poll_valid.
  - On poll in IDLE, treated as an INTA pair collapsed into one cycle: poll_data = {1'b1, {(7-ID_W){0}}, candidate} if a candidate exists, else 8'h00.
  - ISR is set and IRR is cleared exactly as in IDLE->ACK1, with AEOI ignored.
  - poll_valid pulses for one cycle, and int_out is deasserted that cycle.
- Disabled: the ports are absent and there is no poll logic.

Test Plan:
- Fully nested, edge mode, base_vec=5'b01000: pulse ir_in[3] -> int_out=1 two cycles later. Two inta strobes -> vector=8'h43, vector_valid one cycle, ISR=8'h08, IRR=0.
- ISR[3] set; raise ir_in[5] -> int_out stays 0. Raise ir_in[1] -> int_out=1, and after INTA pair vector=8'h41, ISR=8'h0A. eoi -> ISR=8'h08.
- rotate_mode=1, aeoi=1: service IR2 -> ISR=0, prio_ptr=3. Assert ir_in[0] and ir_in[4] together -> next vector id=4.
- IMR=8'hFF, ir_in[6] rise -> IRR[6]=1, int_out=0. imr_wr 8'hBF -> int_out=1.
- Level mode: ir_in[2] rises, int_out=1; first inta; ir_in[2] drops before the second inta -> vector id 2, ISR[2]=1. Repeat with ir_in[2] dropped before the first inta -> the inta is ignored (int_out=0).
- reset asserted in ACK1 -> next cycle state=IDLE, ISR=0, IRR=0, vector_valid never pulses. With POLL_EN, poll with ir_in[1] pending -> poll_data=8'h81.

Source files
------------

// File: rtl/pic_priority_core.sv
// rtl/pic_priority_core.sv - NUM_IR-line priority interrupt core with two-pulse INTA vector handshake
// Optional POLL_EN macro adds a single-cycle poll command returning the current candidate.
module pic_priority_core #(
  parameter int NUM_IR = 8,
  parameter int ID_W   = $clog2(NUM_IR),
  parameter int VEC_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IR-1:0]     ir_in,
  input  logic                  level_mode,
  input  logic                  rotate_mode,
  input  logic                  aeoi,
  input  logic [VEC_W-ID_W-1:0] base_vec,
  input  logic                  imr_wr,
  input  logic [NUM_IR-1:0]     imr_data,
  input  logic                  eoi,
  input  logic                  inta,
`ifdef POLL_EN
  input  logic                  poll,
  output logic [7:0]            poll_data,
  output logic                  poll_valid,
`endif
  output logic                  int_out,
  output logic [VEC_W-1:0]      vector,
  output logic                  vector_valid,
  output logic [NUM_IR-1:0]     irr,
  output logic [NUM_IR-1:0]     isr,
  output logic [NUM_IR-1:0]     imr
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;
  state_t state, state_next;

  logic [NUM_IR-1:0] ir_prev, irr_next, isr_next, irr_clr;
  logic [ID_W-1:0]   prio_ptr, ptr_next, base, sel_id, sel_next;
  logic [ID_W-1:0]   cand_idx, cand_rank, isr_idx, isr_rank;
  logic              spurious, spur_next;
  logic              cand_found, isr_found, int_req, grab, vec_load, poll_hit;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
    logic [ID_W:0] s;
    s = {1'b0, a} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NUM_IR)) s = s - (ID_W+1)'(NUM_IR);
    return s[ID_W-1:0];
  endfunction

`ifdef POLL_EN
  assign poll_hit = (state == IDLE) && poll;
`else
  assign poll_hit = 1'b0;
`endif

  always_comb begin
    base       = rotate_mode ? prio_ptr : '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_rank  = '0;
    isr_found  = 1'b0;
    isr_idx    = '0;
    isr_rank   = '0;
    // Walk from lowest to highest priority so the last hit is the winner
    for (int k = NUM_IR-1; k >= 0; k--) begin
      if (irr[wrap_add(base, k)] && !imr[wrap_add(base, k)]) begin
        cand_found = 1'b1;
        cand_idx   = wrap_add(base, k);
        cand_rank  = ID_W'(k);
      end
      if (isr[wrap_add(base, k)]) begin
        isr_found = 1'b1;
        isr_idx   = wrap_add(base, k);
        isr_rank  = ID_W'(k);
      end
    end
    int_req = cand_found && (!isr_found || cand_rank < isr_rank);
  end

  always_comb begin
    state_next = state;
    isr_next   = isr;
    ptr_next   = prio_ptr;
    sel_next   = sel_id;
    spur_next  = spurious;
    irr_clr    = '0;
    grab       = 1'b0;
    vec_load   = 1'b0;
    // EOI is applied before any same-cycle acknowledge sets a new ISR bit
    if (eoi && isr_found) begin
      isr_next[isr_idx] = 1'b0;
      if (rotate_mode) ptr_next = wrap_add(isr_idx, 1);
    end
    case (state)
      IDLE: begin
        grab = (inta && int_out) || poll_hit;
        if (grab) begin
          if (cand_found) begin
            sel_next           = cand_idx;
            spur_next          = 1'b0;
            isr_next[cand_idx] = 1'b1;
            if (!level_mode) irr_clr[cand_idx] = 1'b1;
          end else begin
            sel_next  = ID_W'(NUM_IR-1);
            spur_next = 1'b1;
          end
        end
        if (inta && int_out) state_next = ACK1;
      end
      ACK1: begin
        if (inta) begin
          state_next = ACK2;
          vec_load   = 1'b1;
          if (aeoi && !spurious) begin
            isr_next[sel_id] = 1'b0;
            if (rotate_mode) ptr_next = wrap_add(sel_id, 1);
          end
        end
      end
      ACK2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A fresh edge beats the acknowledge clear of the same bit
    irr_next = level_mode ? ir_in : ((irr & ~irr_clr) | (ir_in & ~ir_prev));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_prev      <= '0;
      irr          <= '0;
      isr          <= '0;
      imr          <= '0;
      prio_ptr     <= '0;
      sel_id       <= '0;
      spurious     <= 1'b0;
      int_out      <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
`ifdef POLL_EN
      poll_data    <= 8'h00;
      poll_valid   <= 1'b0;
`endif
    end else begin
      ir_prev      <= ir_in;
      irr          <= irr_next;
      isr          <= isr_next;
      imr          <= imr_wr ? imr_data : imr;
      prio_ptr     <= ptr_next;
      sel_id       <= sel_next;
      spurious     <= spur_next;
      int_out      <= int_req && (state_next == IDLE) && !poll_hit;
      vector_valid <= vec_load;
      if (vec_load) vector <= {base_vec, sel_id};
`ifdef POLL_EN
      poll_valid <= poll_hit;
      if (poll_hit) poll_data <= cand_found ? {1'b1, {(7-ID_W){1'b0}}, cand_idx} : 8'h00;
`endif
    end
  end

endmodule

// File: tb/tb_pic_priority_core.sv
// tb/tb_pic_priority_core.sv - scoreboard bench for pic_priority_core (optionally with POLL_EN)
module tb_pic_priority_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, level_mode, rotate_mode, aeoi, imr_wr, eoi, inta;
  logic [7:0] ir_in, imr_data;
  logic [4:0] base_vec;
  logic       int_out, vector_valid;
  logic [7:0] vector, irr, isr, imr;
`ifdef POLL_EN
  logic       poll, poll_valid;
  logic [7:0] poll_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] m_irr, m_isr, m_imr;
  int         m_ptr;

  pic_priority_core #(.NUM_IR(8), .ID_W(3), .VEC_W(8)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .level_mode(level_mode),
    .rotate_mode(rotate_mode), .aeoi(aeoi), .base_vec(base_vec),
    .imr_wr(imr_wr), .imr_data(imr_data), .eoi(eoi), .inta(inta),
`ifdef POLL_EN
    .poll(poll), .poll_data(poll_data), .poll_valid(poll_valid),
`endif
    .int_out(int_out), .vector(vector), .vector_valid(vector_valid),
    .irr(irr), .isr(isr), .imr(imr)
  );

  // Reference model: priority rank is distance from the current top-priority index
  function automatic int rank(int i);
    int b;
    b = rotate_mode ? m_ptr : 0;
    return (i - b + 8) % 8;
  endfunction

  function automatic int top(logic [7:0] v);
    int best;
    best = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  function automatic bit m_int();
    int c, s;
    c = top(m_irr & ~m_imr);
    s = top(m_isr);
    return (c >= 0) && (s < 0 || rank(c) < rank(s));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] bits);
    ir_in = bits;
    m_irr = m_irr | bits;
    tick();
    ir_in = 8'h00;
    tick();
  endtask

  task automatic settle_check(input string tag);
    repeat (3) tick();
    @(negedge clk);
    check({tag, ".int_out"}, {7'b0, int_out}, {7'b0, m_int()});
    check({tag, ".irr"}, irr, m_irr);
    check({tag, ".isr"}, isr, m_isr);
    check({tag, ".imr"}, imr, m_imr);
  endtask

  task automatic inta_pair();
    int c;
    if (m_int()) begin
      c = top(m_irr & ~m_imr);
      exp_q.push_back({base_vec, c[2:0]});
      m_isr[c] = 1'b1;
      m_irr[c] = 1'b0;
      if (aeoi) begin
        m_isr[c] = 1'b0;
        if (rotate_mode) m_ptr = (c + 1) % 8;
      end
    end
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    inta = 1'b1; tick();
    inta = 1'b0;
  endtask

  task automatic do_eoi();
    int s;
    s = top(m_isr);
    if (s >= 0) begin
      m_isr[s] = 1'b0;
      if (rotate_mode) m_ptr = (s + 1) % 8;
    end
    eoi = 1'b1; tick();
    eoi = 1'b0;
  endtask

  task automatic do_imr(input logic [7:0] v);
    imr_data = v;
    imr_wr   = 1'b1;
    m_imr    = v;
    tick();
    imr_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (vector_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL vector_unexpected: got %02h required no vector", vector);
      end else begin
        mon_exp = exp_q.pop_front();
        check("vector", vector, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ir_in = 8'h00; level_mode = 1'b0; rotate_mode = 1'b0; aeoi = 1'b0;
    base_vec = 5'b01000; imr_wr = 1'b0; imr_data = 8'h00; eoi = 1'b0; inta = 1'b0;
`ifdef POLL_EN
    poll = 1'b0;
`endif
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_ptr = 0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst.int_out", {7'b0, int_out}, 8'h00);
    check("rst.irr", irr, 8'h00);
    check("rst.isr", isr, 8'h00);
    check("rst.imr", imr, 8'h00);
    check("rst.vector", vector, 8'h00);
    check("rst.vvalid", {7'b0, vector_valid}, 8'h00);

    // Edge on IR3: int_out appears two edges after the rise
    tick();
    ir_in = 8'h08; m_irr[3] = 1'b1;
    tick();
    ir_in = 8'h00;
    @(negedge clk);
    check("t1.lat1", {7'b0, int_out}, 8'h00);
    tick();
    @(negedge clk);
    check("t1.lat2", {7'b0, int_out}, 8'h01);
    inta_pair();
    settle_check("t1");
    check("t1.vector", vector, 8'h43);
    check("t1.isr", isr, 8'h08);
    check("t1.irr", irr, 8'h00);

    // Nesting: lower-priority IR5 blocked by ISR3, higher IR1 preempts
    pulse(8'h20);
    settle_check("t2a");
    check("t2.blocked", {7'b0, int_out}, 8'h00);
    pulse(8'h02);
    settle_check("t2b");
    check("t2.preempt", {7'b0, int_out}, 8'h01);
    inta_pair();
    settle_check("t2c");
    check("t2.vector", vector, 8'h41);
    check("t2.isr", isr, 8'h0A);
    do_eoi();
    settle_check("t2d");
    check("t2.eoi", isr, 8'h08);
    do_eoi();
    settle_check("t2e");
    inta_pair();
    settle_check("t2f");
    do_eoi();
    settle_check("t2g");

    // Rotating priority with AEOI
    rotate_mode = 1'b1; aeoi = 1'b1;
    pulse(8'h04);
    settle_check("t3a");
    inta_pair();
    settle_check("t3b");
    check("t3.isr", isr, 8'h00);
    pulse(8'h11);
    settle_check("t3c");
    inta_pair();
    settle_check("t3d");
    check("t3.vector", vector, 8'h44);
    inta_pair();
    settle_check("t3e");

    // Masking
    do_imr(8'hFF);
    pulse(8'h40);
    settle_check("t4a");
    check("t4.irr", irr, 8'h40);
    check("t4.masked", {7'b0, int_out}, 8'h00);
    do_imr(8'hBF);
    settle_check("t4b");
    check("t4.unmasked", {7'b0, int_out}, 8'h01);
    inta_pair();
    settle_check("t4c");
    do_imr(8'h00);
    settle_check("t4d");

    // Level mode: request withdrawn after vs before the first inta
    rotate_mode = 1'b0; aeoi = 1'b0; level_mode = 1'b1;
    ir_in = 8'h04;
    repeat (3) tick();
    @(negedge clk);
    check("t5.int_out", {7'b0, int_out}, 8'h01);
    exp_q.push_back({base_vec, 3'd2});
    inta = 1'b1; tick();
    inta = 1'b0; ir_in = 8'h00; tick();
    inta = 1'b1; tick();
    inta = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("t5.isr", isr, 8'h04);
    check("t5.vector", vector, 8'h42);
    eoi = 1'b1; tick(); eoi = 1'b0;
    ir_in = 8'h04;
    repeat (3) tick();
    ir_in = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("t5.withdrawn", {7'b0, int_out}, 8'h00);
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    inta = 1'b1; tick();
    inta = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("t5.ignored", isr, 8'h00);
    level_mode = 1'b0;
    settle_check("t5");

    // Reset aborts a handshake in ACK1
    pulse(8'h08);
    settle_check("t6a");
    inta = 1'b1; tick();
    inta = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_ptr = 0;
    @(negedge clk);
    check("t6.isr", isr, 8'h00);
    check("t6.irr", irr, 8'h00);
    inta = 1'b1; tick(); inta = 1'b0;
    settle_check("t6b");

`ifdef POLL_EN
    pulse(8'h02);
    settle_check("t7a");
    poll = 1'b1; tick(); poll = 1'b0;
    @(negedge clk);
    check("t7.poll_valid", {7'b0, poll_valid}, 8'h01);
    check("t7.poll_data", poll_data, 8'h81);
    check("t7.int_out", {7'b0, int_out}, 8'h00);
    m_isr[1] = 1'b1; m_irr[1] = 1'b0;
    settle_check("t7b");
    do_eoi();
    settle_check("t7c");
`endif

    for (int blk = 0; blk < 4; blk++) begin
      rotate_mode = 1'($urandom_range(0, 1));
      aeoi        = 1'($urandom_range(0, 1));
      base_vec    = 5'($urandom);
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 5))
          0, 1:    pulse(8'($urandom));
          2:       do_eoi();
          3:       do_imr(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
          default: inta_pair();
        endcase
        settle_check("rnd");
      end
    end

    repeat (4) tick();
    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
